// File: rtl/datapath_issue_ctrl.sv
// ---------------------------------------------------------------------------
// datapath_issue_ctrl
//   Issue/control stage for a register-file + ALU datapath. MIPS R/I-type ALU
//   instructions are queued in a small FIFO, then decoded one at a time into
//   register-file and ALU controls. ALUResult is looped back as write data.
//   Immediates and shift amounts have no direct ALU input, so they are first
//   written into a reserved scratch register (STAGE), then used as an
//   ordinary register operand (EXEC).
//
// Ports
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   instr/instr_valid  instruction word and its valid strobe
//   instr_ready        FIFO not full; a push happens on valid && ready
//   RegWrite           register-file write enable
//   ReadAddr1/2        ALU operand A (shift amount) / operand B registers
//   WriteAddr          destination register
//   ALUFN              ALU function code
//   WriteData          register-file write data
//   ALUResult          combinational ALU result from the datapath
//   busy               FIFO non-empty or FSM not idle
//   illegal            one-cycle pulse when an unsupported instruction is dropped
// ---------------------------------------------------------------------------
module datapath_issue_ctrl #(
   parameter int Nloc    = 32,
   parameter int Dbits   = 32,
   parameter int DEPTH   = 4,
   parameter int SCRATCH = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [31:0]             instr,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   output logic                    RegWrite,
   output logic [$clog2(Nloc)-1:0] ReadAddr1,
   output logic [$clog2(Nloc)-1:0] ReadAddr2,
   output logic [$clog2(Nloc)-1:0] WriteAddr,
   output logic [4:0]              ALUFN,
   output logic [Dbits-1:0]        WriteData,
   input  logic [Dbits-1:0]        ALUResult,
   output logic                    busy,
   output logic                    illegal
);

   localparam int LGN = $clog2(Nloc);
   localparam int PW  = $clog2(DEPTH);

   localparam logic [4:0] FN_ADD = 5'b00001;
   localparam logic [4:0] FN_SUB = 5'b10001;
   localparam logic [4:0] FN_SLL = 5'b00010;
   localparam logic [4:0] FN_SRL = 5'b01010;
   localparam logic [4:0] FN_SRA = 5'b01110;
   localparam logic [4:0] FN_AND = 5'b00000;
   localparam logic [4:0] FN_OR  = 5'b00100;
   localparam logic [4:0] FN_XOR = 5'b01000;
   localparam logic [4:0] FN_NOR = 5'b01100;
   localparam logic [4:0] FN_LT  = 5'b10011;
   localparam logic [4:0] FN_LTU = 5'b10111;

   typedef enum logic [1:0] {S_IDLE, S_STAGE, S_EXEC} state_t;

   typedef struct packed {
      logic       legal;
      logic       rtype;
      logic       is_shamt;   // shift by instruction shamt field
      logic       is_lui;
      logic       zext;       // logical immediates are zero-extended
      logic [4:0] fn;
   } dec_t;

   function automatic dec_t f_decode(input logic [31:0] w);
      dec_t d;
      d       = '0;
      d.legal = 1'b1;
      if (w[31:26] == 6'h00) begin
         d.rtype = 1'b1;
         case (w[5:0])
            6'h00:       begin d.fn = FN_SLL; d.is_shamt = 1'b1; end
            6'h02:       begin d.fn = FN_SRL; d.is_shamt = 1'b1; end
            6'h03:       begin d.fn = FN_SRA; d.is_shamt = 1'b1; end
            6'h04:       d.fn = FN_SLL;
            6'h06:       d.fn = FN_SRL;
            6'h07:       d.fn = FN_SRA;
            6'h20, 6'h21: d.fn = FN_ADD;
            6'h22, 6'h23: d.fn = FN_SUB;
            6'h24:       d.fn = FN_AND;
            6'h25:       d.fn = FN_OR;
            6'h26:       d.fn = FN_XOR;
            6'h27:       d.fn = FN_NOR;
            6'h2A:       d.fn = FN_LT;
            6'h2B:       d.fn = FN_LTU;
            default:     d.legal = 1'b0;
         endcase
      end else begin
         case (w[31:26])
            6'h08, 6'h09: d.fn = FN_ADD;
            6'h0A:       d.fn = FN_LT;
            6'h0B:       d.fn = FN_LTU;
            6'h0C:       begin d.fn = FN_AND; d.zext = 1'b1; end
            6'h0D:       begin d.fn = FN_OR;  d.zext = 1'b1; end
            6'h0E:       begin d.fn = FN_XOR; d.zext = 1'b1; end
            6'h0F:       d.is_lui = 1'b1;
            default:     d.legal = 1'b0;
         endcase
      end
      return d;
   endfunction

   function automatic logic [4:0] f_dest(input logic [31:0] w, input dec_t d);
      return d.rtype ? w[15:11] : w[20:16];
   endfunction

   // Two-phase ops: every I-type ALU op except lui, and shamt shifts.
   // Writes to r0 are discarded, so their staging is skipped too.
   function automatic logic f_needs_stage(input logic [31:0] w);
      dec_t d;
      d = f_decode(w);
      return d.legal && !d.is_lui && (!d.rtype || d.is_shamt) && (f_dest(w, d) != 5'd0);
   endfunction

   // ---------------- instruction FIFO ----------------
   logic [31:0] r_mem [DEPTH];
   logic [PW:0] r_wptr, r_rptr;
   logic        w_full, w_empty, w_push, w_pop;
   logic [31:0] w_head;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_empty = (r_wptr == r_rptr);
   assign w_push  = instr_valid && !w_full;
   assign w_head  = r_mem[r_rptr[PW-1:0]];

   // NOTE: FIFO storage has no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr[PW-1:0]] <= instr;
   end

   // ---------------- FSM ----------------
   state_t      r_state, w_next;
   logic [31:0] r_ir;

   assign w_pop = !w_empty && (r_state == S_IDLE || r_state == S_EXEC);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_state <= w_next;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_ir   <= w_head;
         end
      end
   end

   dec_t       w_dec;
   logic [4:0] w_dest;

   assign w_dec  = f_decode(r_ir);
   assign w_dest = f_dest(r_ir, w_dec);

   // NOTE: every output and next-state signal gets a default first, so no
   // path through the case can leave a value held (no latches).
   always_comb begin
      w_next    = r_state;
      RegWrite  = 1'b0;
      ReadAddr1 = '0;
      ReadAddr2 = '0;
      WriteAddr = '0;
      ALUFN     = '0;
      WriteData = '0;
      illegal   = 1'b0;

      case (r_state)
         S_STAGE: begin
            w_next    = S_EXEC;
            RegWrite  = 1'b1;
            WriteAddr = LGN'(SCRATCH);
            if (w_dec.is_shamt)  WriteData = Dbits'(r_ir[10:6]);
            else if (w_dec.zext) WriteData = Dbits'({16'h0000, r_ir[15:0]});
            else                 WriteData = Dbits'({{16{r_ir[15]}}, r_ir[15:0]});
         end
         S_EXEC: begin
            if (!w_dec.legal) begin
               illegal = 1'b1;
            end else if (w_dest != 5'd0) begin
               RegWrite  = 1'b1;
               WriteAddr = LGN'(w_dest);
               if (w_dec.is_lui) begin
                  WriteData = Dbits'({r_ir[15:0], 16'h0000});
               end else begin
                  ALUFN     = w_dec.fn;
                  WriteData = ALUResult;
                  if (w_dec.rtype) begin
                     ReadAddr1 = w_dec.is_shamt ? LGN'(SCRATCH) : LGN'(r_ir[25:21]);
                     ReadAddr2 = LGN'(r_ir[20:16]);
                  end else begin
                     ReadAddr1 = LGN'(r_ir[25:21]);
                     ReadAddr2 = LGN'(SCRATCH);
                  end
               end
            end
         end
         default: ;
      endcase

      // Leaving IDLE or finishing EXEC both pick up the next queued instruction.
      if (r_state != S_STAGE) begin
         if (w_pop) w_next = f_needs_stage(w_head) ? S_STAGE : S_EXEC;
         else       w_next = S_IDLE;
      end
   end

   assign instr_ready = !w_full;
   assign busy        = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_datapath_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_datapath_issue_ctrl
//   Directed bench for datapath_issue_ctrl. Each accepted instruction is
//   expanded by a reference model into the expected STAGE/EXEC output cycles
//   and queued; a monitor compares every visible output cycle (RegWrite or
//   illegal high) against the queue head. ALUResult is a tb-side function of
//   the ALU controls so loop-back data is checkable.
// ---------------------------------------------------------------------------
module tb_datapath_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic        RegWrite;
   logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr;
   logic [4:0]  ALUFN;
   logic [31:0] WriteData;
   logic [31:0] ALUResult;
   logic        busy, illegal;

   datapath_issue_ctrl dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .RegWrite    (RegWrite),
      .ReadAddr1   (ReadAddr1),
      .ReadAddr2   (ReadAddr2),
      .WriteAddr   (WriteAddr),
      .ALUFN       (ALUFN),
      .WriteData   (WriteData),
      .ALUResult   (ALUResult),
      .busy        (busy),
      .illegal     (illegal)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] alu_hash(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] fn);
      return {fn, a, b, 17'h1A5A5};
   endfunction

   assign ALUResult = alu_hash(ReadAddr1, ReadAddr2, ALUFN);

   typedef struct packed {
      logic        rw;
      logic [4:0]  ra1, ra2, wa, fn;
      logic [31:0] wd;
      logic        ill;
      logic        chk_fn;
   } exp_t;

   exp_t exp_q[$];
   int   stamps[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   ev_count = 0;
   bit   mon_en = 1'b0;
   bit   saw_full = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected visible output cycles of one instruction.
   task automatic model_push(input logic [31:0] w);
      exp_t       e;
      logic [5:0] op, fu;
      logic [4:0] rs, rt, rd, sh, fn, dest;
      logic [15:0] imm;
      logic       ok, rtype, shamt, lui, zext;
      op = w[31:26]; fu = w[5:0]; rs = w[25:21]; rt = w[20:16];
      rd = w[15:11]; sh = w[10:6]; imm = w[15:0];
      ok = 1'b1; rtype = (op == 6'h00); shamt = 1'b0; lui = 1'b0; zext = 1'b0; fn = 5'b0;
      if (rtype) begin
         case (fu)
            6'h00: begin fn = 5'b00010; shamt = 1'b1; end
            6'h02: begin fn = 5'b01010; shamt = 1'b1; end
            6'h03: begin fn = 5'b01110; shamt = 1'b1; end
            6'h04: fn = 5'b00010;
            6'h06: fn = 5'b01010;
            6'h07: fn = 5'b01110;
            6'h20, 6'h21: fn = 5'b00001;
            6'h22, 6'h23: fn = 5'b10001;
            6'h24: fn = 5'b00000;
            6'h25: fn = 5'b00100;
            6'h26: fn = 5'b01000;
            6'h27: fn = 5'b01100;
            6'h2A: fn = 5'b10011;
            6'h2B: fn = 5'b10111;
            default: ok = 1'b0;
         endcase
      end else begin
         case (op)
            6'h08, 6'h09: fn = 5'b00001;
            6'h0A: fn = 5'b10011;
            6'h0B: fn = 5'b10111;
            6'h0C: begin fn = 5'b00000; zext = 1'b1; end
            6'h0D: begin fn = 5'b00100; zext = 1'b1; end
            6'h0E: begin fn = 5'b01000; zext = 1'b1; end
            6'h0F: lui = 1'b1;
            default: ok = 1'b0;
         endcase
      end
      dest = rtype ? rd : rt;
      e = '0;
      e.chk_fn = 1'b1;
      if (!ok) begin
         e.ill = 1'b1;
         exp_q.push_back(e);
      end else if (dest != 5'd0) begin
         if (!lui && (!rtype || shamt)) begin
            e.rw = 1'b1; e.wa = 5'd1;
            e.wd = shamt ? {27'b0, sh} : zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
            exp_q.push_back(e);
         end
         e = '0;
         e.rw = 1'b1; e.wa = dest; e.chk_fn = 1'b1;
         if (lui) begin
            e.wd = {imm, 16'h0000};
            e.chk_fn = 1'b0;
         end else begin
            e.fn  = fn;
            e.ra1 = rtype ? (shamt ? 5'd1 : rs) : rs;
            e.ra2 = rtype ? rt : 5'd1;
            e.wd  = alu_hash(e.ra1, e.ra2, fn);
         end
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (mon_en && reset_n && (RegWrite || illegal)) begin
         ev_count++;
         stamps.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_output_cycle", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("RegWrite",  RegWrite,  e.rw);
            check("ReadAddr1", ReadAddr1, e.ra1);
            check("ReadAddr2", ReadAddr2, e.ra2);
            check("WriteAddr", WriteAddr, e.wa);
            if (e.chk_fn) check("ALUFN", ALUFN, e.fn);
            check("WriteData", WriteData, e.wd);
            check("illegal",   illegal,   e.ill);
         end
      end
   end

   // Drive one instruction; returns the cycle stamp of the accepting edge.
   task automatic push(input logic [31:0] w, output int acc);
      int n;
      n = 0;
      acc = -1;
      @(negedge clock);
      instr = w;
      instr_valid = 1'b1;
      #1;
      while (!instr_ready && n < 50) begin
         saw_full = 1'b1;
         @(negedge clock);
         #1;
         n++;
      end
      if (!instr_ready) begin
         check("push_ready_timeout", instr_ready, 1'b1);
         instr_valid = 1'b0;
      end else begin
         @(posedge clock);
         model_push(w);
         #1;
         acc = cyc;
         instr_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("drain_within_budget", 64'(n < 200), 64'd1);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("busy_after_drain", busy, 1'b0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_RegWrite"}, RegWrite, 1'b0);
      check({tag, "_addrs"}, {ReadAddr1, ReadAddr2, WriteAddr, ALUFN}, 20'h0);
      check({tag, "_WriteData"}, WriteData, 32'h0);
      check({tag, "_illegal"}, illegal, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_ready"}, instr_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, k, n, ev0;
      logic [31:0] w;
      logic [31:0] mix [10];

      // Reset state
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      @(negedge clock);
      check_idle_outputs("post_reset");
      mon_en = 1'b1;

      // addi r2,r0,5: STAGE one cycle after acceptance, EXEC the next
      k = stamps.size();
      push(32'h20020005, a0);
      drain();
      check("addi_stage_cycle", 64'(stamps[k]), 64'(a0 + 1));
      check("addi_exec_cycle",  64'(stamps[k+1]), 64'(a0 + 2));

      // add then lui back-to-back: consecutive EXEC cycles
      k = stamps.size();
      push(32'h00421820, a0);
      push(32'h3C04ABCD, a1);
      drain();
      check("add_exec_cycle", 64'(stamps[k]), 64'(a0 + 1));
      check("lui_exec_cycle", 64'(stamps[k+1]), 64'(a0 + 2));

      // Shifts, sign/zero extension and a mix of R/I-type ops
      mix[0] = 32'h000230C0;                               // sll r6,r2,3
      mix[1] = 32'h2045FFFF;                               // addi r5,r2,-1
      mix[2] = 32'h3045FFFF;                               // andi r5,r2,0xFFFF
      mix[3] = {6'h00, 5'd3, 5'd2, 5'd7, 5'd0, 6'h04};     // sllv r7,r2,r3
      mix[4] = {6'h00, 5'd0, 5'd8, 5'd9, 5'd31, 6'h03};    // sra r9,r8,31
      mix[5] = {6'h00, 5'd4, 5'd5, 5'd10, 5'd0, 6'h23};    // subu r10,r4,r5
      mix[6] = {6'h00, 5'd6, 5'd7, 5'd11, 5'd0, 6'h2B};    // sltu r11,r6,r7
      mix[7] = {6'h0E, 5'd3, 5'd12, 16'h8001};             // xori r12,r3,0x8001
      mix[8] = {6'h0A, 5'd4, 5'd13, 16'h8000};             // slti r13,r4,-32768
      mix[9] = {6'h00, 5'd2, 5'd3, 5'd14, 5'd0, 6'h27};    // nor r14,r2,r3
      for (int i = 0; i < 10; i++) push(mix[i], a0);
      drain();

      // Destination r0 and nop: no visible writes, FSM returns idle
      ev0 = ev_count;
      push(32'h00000000, a0);
      push(32'h00430020, a0);
      drain();
      check("r0_dest_no_writes", 64'(ev_count - ev0), 64'd0);

      // Hold valid with 8 two-phase addi: FIFO fills, order preserved
      saw_full = 1'b0;
      ev0 = ev_count;
      for (int i = 0; i < 8; i++) begin
         w = {6'h08, 5'd2, 5'(8 + i), 16'(i * 3 + 1)};
         push(w, a0);
      end
      drain();
      check("ready_dropped_when_full", saw_full, 1'b1);
      check("burst_write_count", 64'(ev_count - ev0), 64'd16);

      // Unsupported instructions: one illegal pulse each, no write
      ev0 = ev_count;
      push(32'h8C410000, a0);                              // lw
      push(32'h03E00008, a0);                              // jr ra
      drain();
      check("illegal_pulse_count", 64'(ev_count - ev0), 64'd2);

      // Reset during STAGE with another instruction still queued
      mon_en = 1'b0;
      push(32'h20020011, a0);
      push(32'h20030022, a0);
      push(32'h20040033, a0);
      n = 0;
      while (!(RegWrite && WriteAddr == 5'd1) && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("stage_seen_before_reset", RegWrite && WriteAddr == 5'd1, 1'b1);
      #1 reset_n = 1'b0;
      @(negedge clock);
      check_idle_outputs("mid_stage_reset");
      reset_n = 1'b1;
      exp_q.delete();
      ev0 = ev_count;
      mon_en = 1'b1;
      repeat (10) @(negedge clock);
      check("fifo_discarded_on_reset", 64'(ev_count - ev0), 64'd0);
      check("busy_after_reset", busy, 1'b0);

      // Operation resumes normally after reset
      k = stamps.size();
      push(32'h20020007, a0);
      drain();
      check("resume_exec_cycle", 64'(stamps[k+1]), 64'(a0 + 2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
